// File: rtl/univ_reg_pkg.sv
// Shared mode codes, state encoding and helpers for the universal register.
package univ_reg_pkg;

   localparam logic [2:0] MODE_HOLD   = 3'd0;
   localparam logic [2:0] MODE_LOAD   = 3'd1;
   localparam logic [2:0] MODE_TOGGLE = 3'd2;
   localparam logic [2:0] MODE_SHL    = 3'd3;
   localparam logic [2:0] MODE_SHR    = 3'd4;
   localparam logic [2:0] MODE_ROTL   = 3'd5;
   localparam logic [2:0] MODE_ROTR   = 3'd6;
   localparam logic [2:0] MODE_CLEAR  = 3'd7;

   typedef enum logic {
      ST_IDLE,
      ST_STEP
   } state_e;

   function automatic logic is_shift(input logic [2:0] mode);
      return (mode >= MODE_SHL) && (mode <= MODE_ROTR);
   endfunction

endpackage

// File: rtl/univ_reg_step.sv
// Combinational single-step datapath: next register value and the displaced bit.
module univ_reg_step
   import univ_reg_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             ser_in,
   output logic [WIDTH-1:0] next_q,
   output logic             shift_bit
);

   always_comb begin
      next_q    = q;
      shift_bit = 1'b0;
      unique case (mode)
         MODE_HOLD:   next_q = q;
         MODE_LOAD:   next_q = d;
         MODE_TOGGLE: next_q = q ^ d;
         MODE_SHL: begin
            next_q    = {q[WIDTH-2:0], ser_in};
            shift_bit = q[WIDTH-1];
         end
         MODE_SHR: begin
            next_q    = {ser_in, q[WIDTH-1:1]};
            shift_bit = q[0];
         end
         MODE_ROTL: begin
            next_q    = {q[WIDTH-2:0], q[WIDTH-1]};
            shift_bit = q[WIDTH-1];
         end
         MODE_ROTR: begin
            next_q    = {q[0], q[WIDTH-1:1]};
            shift_bit = q[0];
         end
         MODE_CLEAR:  next_q = '0;
         default:     next_q = q;
      endcase
   end

endmodule

// File: rtl/univ_reg.sv
// Universal register: load/toggle/clear plus multi-cycle shift/rotate with
// serial in/out and a start/busy/done handshake.
module univ_reg
   import univ_reg_pkg::*;
#(
   parameter int unsigned         WIDTH     = 8,
   parameter logic [WIDTH-1:0]    RESET_VAL = '0,
   localparam int unsigned        AW        = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic [AW-1:0]    amt,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [AW-1:0]    rem_q, rem_d;
   logic [2:0]       mode_q, mode_d;
   logic [WIDTH-1:0] q_d;
   logic             ser_out_d, done_d;
   logic [2:0]       step_mode;
   logic [WIDTH-1:0] step_q;
   logic             step_bit;

   // The accept edge uses the live mode; STEP edges replay the captured one.
   assign step_mode = (state_q == ST_STEP) ? mode_q : mode;

   univ_reg_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .q         (q),
      .mode      (step_mode),
      .d         (d),
      .ser_in    (ser_in),
      .next_q    (step_q),
      .shift_bit (step_bit)
   );

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      mode_d    = mode_q;
      q_d       = q;
      ser_out_d = ser_out;
      done_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (!is_shift(mode)) begin
                  q_d    = step_q;
                  done_d = 1'b1;
               end else if (amt == '0) begin
                  done_d = 1'b1;
               end else begin
                  q_d       = step_q;
                  ser_out_d = step_bit;
                  if (amt == AW'(1)) begin
                     done_d = 1'b1;
                  end else begin
                     rem_d   = amt - AW'(1);
                     mode_d  = mode;
                     state_d = ST_STEP;
                  end
               end
            end
         end
         ST_STEP: begin
            q_d       = step_q;
            ser_out_d = step_bit;
            rem_d     = rem_q - AW'(1);
            if (rem_q == AW'(1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         mode_q  <= MODE_HOLD;
         q       <= RESET_VAL;
         ser_out <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (set) begin
         // Abort anything in flight; ser_out deliberately keeps its value.
         state_q <= ST_IDLE;
         rem_q   <= '0;
         q       <= '1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
         q       <= q_d;
         ser_out <= ser_out_d;
         busy    <= (state_d == ST_STEP);
         done    <= done_d;
      end
   end

   assign qb = ~q;

endmodule

// File: tb/tb_univ_reg.sv
// Directed self-checking bench for univ_reg (WIDTH=8, RESET_VAL=0).
module tb_univ_reg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned AW    = $clog2(WIDTH) + 1;

   logic             clk = 1'b0;
   logic             reset, set, start, ser_in;
   logic [2:0]       mode;
   logic [WIDTH-1:0] d;
   logic [AW-1:0]    amt;
   logic [WIDTH-1:0] q, qb;
   logic             ser_out, busy, done;

   int checks = 0;
   int errors = 0;

   univ_reg #(
      .WIDTH     (WIDTH),
      .RESET_VAL (8'h00)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .set     (set),
      .start   (start),
      .mode    (mode),
      .d       (d),
      .amt     (amt),
      .ser_in  (ser_in),
      .q       (q),
      .qb      (qb),
      .ser_out (ser_out),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] m, input logic [WIDTH-1:0] dv, input logic [AW-1:0] a);
      mode  = m;
      d     = dv;
      amt   = a;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   logic [7:0] shl_bits;
   int         done_cnt;

   initial begin
      reset = 1'b1; set = 1'b0; start = 1'b0; ser_in = 1'b0;
      mode = 3'd0; d = '0; amt = '0;
      tick(); tick();
      reset = 1'b0;
      check("rst_q", q, 8'h00);
      check("rst_qb", qb, 8'hFF);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ser", ser_out, 0);

      // LOAD then back-to-back TOGGLE issued while done is high
      mode = 3'd1; d = 8'hA5; start = 1'b1;
      tick();
      check("load_q", q, 8'hA5);
      check("load_qb", qb, 8'h5A);
      check("load_done", done, 1);
      check("load_busy", busy, 0);
      mode = 3'd2; d = 8'hFF;
      tick();
      start = 1'b0;
      check("tog_q", q, 8'h5A);
      check("tog_done", done, 1);
      tick();
      check("tog_done_low", done, 0);

      // ROTL by 3 from 0x81
      issue(3'd1, 8'h81, '0);
      issue(3'd5, 8'h00, AW'(3));
      check("rotl1_q", q, 8'h03);
      check("rotl1_ser", ser_out, 1);
      check("rotl1_busy", busy, 1);
      check("rotl1_done", done, 0);
      tick();
      check("rotl2_q", q, 8'h06);
      check("rotl2_ser", ser_out, 0);
      check("rotl2_busy", busy, 1);
      tick();
      check("rotl3_q", q, 8'h0C);
      check("rotl3_ser", ser_out, 0);
      check("rotl3_busy", busy, 0);
      check("rotl3_done", done, 1);
      tick();
      check("rotl_done_low", done, 0);

      // SHL by 8 with serial input; a LOAD attempted mid-way must be ignored
      issue(3'd7, 8'h00, '0);
      shl_bits = 8'b0100_1101;  // bit i is fed at step i+1
      done_cnt = 0;
      mode = 3'd3; amt = AW'(8); ser_in = shl_bits[0]; start = 1'b1;
      tick();
      start = 1'b0;
      if (done) done_cnt++;
      for (int i = 1; i < 8; i++) begin
         ser_in = shl_bits[i];
         if (i == 3) begin
            mode = 3'd1; d = 8'h11; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         if (done) done_cnt++;
      end
      start = 1'b0;
      check("shl_q", q, 8'hB2);
      check("shl_ser", ser_out, 0);
      check("shl_done", done, 1);
      check("shl_busy", busy, 0);
      tick();
      if (done) done_cnt++;
      check("shl_done_once", done_cnt, 1);

      // Abort SHR by set after two steps
      issue(3'd1, 8'h3E, '0);
      ser_in = 1'b0;
      issue(3'd4, 8'h00, AW'(5));
      check("shr1_q", q, 8'h1F);
      tick();
      check("shr2_q", q, 8'h0F);
      check("shr2_ser", ser_out, 1);
      check("shr2_busy", busy, 1);
      set = 1'b1;
      tick();
      set = 1'b0;
      check("set_q", q, 8'hFF);
      check("set_qb", qb, 8'h00);
      check("set_busy", busy, 0);
      check("set_done", done, 0);
      check("set_ser", ser_out, 1);
      tick(); tick();
      check("abort_no_done", done, 0);
      check("abort_q_hold", q, 8'hFF);
      issue(3'd1, 8'h42, '0);
      check("post_abort_q", q, 8'h42);
      check("post_abort_done", done, 1);

      // amt=0 SHR: no change, done pulse, ser_out kept
      issue(3'd4, 8'h00, '0);
      check("amt0_q", q, 8'h42);
      check("amt0_done", done, 1);
      check("amt0_busy", busy, 0);
      check("amt0_ser", ser_out, 1);

      // reset wins over set and start together
      reset = 1'b1; set = 1'b1;
      issue(3'd1, 8'h77, '0);
      reset = 1'b0; set = 1'b0;
      check("rst_pri_q", q, 8'h00);
      check("rst_pri_done", done, 0);
      check("rst_pri_ser", ser_out, 0);
      check("rst_pri_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
